// File: rtl/board_renderer.sv
// Playfield renderer: converts timing-generator pixel coordinates into board
// RAM reads and 12-bit RGB. Three registered stages (track/address, RAM data,
// colour) keep rgb and the delayed syncs aligned. Cell addressing uses running
// counters, so the datapath contains no dividers or multipliers.
// pix_en is a one-clock strobe; every register advances only when it is high.
module board_renderer #(
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int CELL         = 20,
  parameter int ORIGIN_X     = 220,
  parameter int ORIGIN_Y     = 40,
  parameter int ADDR_WIDTH   = 12,
  parameter int BASE_ADDR    = 0,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pix_en,
  input  logic [9:0]            x,
  input  logic [8:0]            y,
  input  logic                  active,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  screen_end,
  input  logic                  grid_en,
  input  logic [ROWS-1:0]       clear_rows,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  input  logic [2:0]            mem_data,
  output logic [11:0]           rgb,
  output logic                  hsync_out,
  output logic                  vsync_out
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SUB_W = $clog2(CELL);
  localparam int FC_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [9:0]            X_LO     = 10'(ORIGIN_X);
  localparam logic [9:0]            X_HI     = 10'(ORIGIN_X + COLS * CELL);
  localparam logic [8:0]            Y_LO     = 9'(ORIGIN_Y);
  localparam logic [8:0]            Y_HI     = 9'(ORIGIN_Y + ROWS * CELL);
  localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(CELL - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [FC_W-1:0]       FC_LAST  = FC_W'(FLASH_FRAMES - 1);

  // Fixed cell-code palette.
  function automatic logic [11:0] palette(input logic [2:0] code);
    logic [11:0] c;
    case (code)
      3'd0:    c = 12'h000;
      3'd1:    c = 12'h0FF;
      3'd2:    c = 12'hFF0;
      3'd3:    c = 12'h4F0;
      3'd4:    c = 12'hF00;
      3'd5:    c = 12'hA0F;
      3'd6:    c = 12'hE80;
      default: c = 12'h02F;
    endcase
    return c;
  endfunction

  // Region decode of the incoming pixel.
  logic x_at_org, x_in, y_at_org, y_in, in_board;
  assign x_at_org = (x == X_LO);
  assign x_in     = (x >= X_LO) && (x < X_HI);
  assign y_at_org = (y == Y_LO);
  assign y_in     = (y >= Y_LO) && (y < Y_HI);
  assign in_board = x_in && y_in && active;

  // Tracking counters: _q holds the previous pixel, _d the current one.
  logic [COL_W-1:0]      col_q, col_d;
  logic [SUB_W-1:0]      xsub_q, xsub_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [SUB_W-1:0]      ysub_q, ysub_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

  // Stage 1 registers.
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_ren_q;
  logic                  s1_inb_q, s1_grid_q, s1_act_q, s1_hs_q, s1_vs_q;
  logic [ROW_W-1:0]      s1_row_q;

  // Stage 2 registers.
  logic [2:0]            s2_code_q;
  logic                  s2_inb_q, s2_grid_q, s2_act_q, s2_hs_q, s2_vs_q;
  logic [ROW_W-1:0]      s2_row_q;

  // Stage 3 (output) registers.
  logic [11:0]           rgb_q, rgb_d;
  logic                  hsync_q, vsync_q;

  // Flash animation state.
  logic [ROWS-1:0]       flash_mask_q, flash_mask_d;
  logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                  phase_q, phase_d;

  logic                  is_grid_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  // Next cell position: restart at the board's left edge, step inside it;
  // the vertical counters move once per line at the left-edge pixel.
  always_comb begin
    col_d      = col_q;
    xsub_d     = xsub_q;
    row_d      = row_q;
    ysub_d     = ysub_q;
    row_base_d = row_base_q;
    if (x_at_org) begin
      col_d  = '0;
      xsub_d = '0;
      if (y_at_org) begin
        row_d      = '0;
        ysub_d     = '0;
        row_base_d = '0;
      end else if (y_in) begin
        if (ysub_q == SUB_LAST) begin
          ysub_d     = '0;
          row_d      = row_q + ROW_W'(1);
          row_base_d = row_base_q + COL_STEP;
        end else begin
          ysub_d = ysub_q + SUB_W'(1);
        end
      end
    end else if (x_in) begin
      if (xsub_q == SUB_LAST) begin
        xsub_d = '0;
        col_d  = col_q + COL_W'(1);
      end else begin
        xsub_d = xsub_q + SUB_W'(1);
      end
    end
  end

  assign is_grid_d = (xsub_d == '0) || (xsub_d == SUB_LAST) ||
                     (ysub_d == '0) || (ysub_d == SUB_LAST);
  assign addr_d    = BASE + row_base_d + ADDR_WIDTH'(col_d);

  // Flash update at the frame boundary; an empty mask parks the animation.
  always_comb begin
    flash_mask_d = flash_mask_q;
    frame_cnt_d  = frame_cnt_q;
    phase_d      = phase_q;
    if (screen_end) begin
      flash_mask_d = clear_rows;
      if (clear_rows == '0) begin
        frame_cnt_d = '0;
        phase_d     = 1'b0;
      end else if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  // Colour selection in priority order: blanking, outside, grid, flash, cell.
  always_comb begin
    rgb_d = palette(s2_code_q);
    if (!s2_act_q || !s2_inb_q) begin
      rgb_d = 12'h000;
    end else if (grid_en && s2_grid_q) begin
      rgb_d = 12'hFFF;
    end else if (flash_mask_q[s2_row_q] && phase_q) begin
      rgb_d = 12'hFFF;
    end
  end

  // Tracking counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q      <= '0;
      xsub_q     <= '0;
      row_q      <= '0;
      ysub_q     <= '0;
      row_base_q <= '0;
    end else if (pix_en) begin
      col_q      <= col_d;
      xsub_q     <= xsub_d;
      row_q      <= row_d;
      ysub_q     <= ysub_d;
      row_base_q <= row_base_d;
    end
  end

  // Stage 1: issue the RAM read; the address holds while outside the board.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr_q <= BASE;
      mem_ren_q  <= 1'b0;
      s1_inb_q   <= 1'b0;
      s1_grid_q  <= 1'b0;
      s1_act_q   <= 1'b0;
      s1_row_q   <= '0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
    end else if (pix_en) begin
      if (in_board) begin
        mem_addr_q <= addr_d;
      end
      mem_ren_q <= in_board;
      s1_inb_q  <= in_board;
      s1_grid_q <= is_grid_d;
      s1_act_q  <= active;
      s1_row_q  <= row_d;
      s1_hs_q   <= hsync_in;
      s1_vs_q   <= vsync_in;
    end
  end

  // Stage 2: capture the cell code and forward the pixel flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_code_q <= '0;
      s2_inb_q  <= 1'b0;
      s2_grid_q <= 1'b0;
      s2_act_q  <= 1'b0;
      s2_row_q  <= '0;
      s2_hs_q   <= 1'b1;
      s2_vs_q   <= 1'b1;
    end else if (pix_en) begin
      s2_code_q <= mem_data;
      s2_inb_q  <= s1_inb_q;
      s2_grid_q <= s1_grid_q;
      s2_act_q  <= s1_act_q;
      s2_row_q  <= s1_row_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
    end
  end

  // Stage 3: registered colour and syncs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix_en) begin
      rgb_q   <= rgb_d;
      hsync_q <= s2_hs_q;
      vsync_q <= s2_vs_q;
    end
  end

  // Flash mask, frame counter and phase registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flash_mask_q <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else if (pix_en) begin
      flash_mask_q <= flash_mask_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_ren   = mem_ren_q;
  assign rgb       = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: a default-geometry instance (two-frame
// flash half-period) driven by line scans, plus an alternate-geometry
// instance sharing the same pixel stream for the address mapping check.
module tb_board_renderer;

  localparam int OX   = 220;
  localparam int OY   = 40;
  localparam int CELL = 20;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int FF   = 2;

  // Clock and reset
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DUT signals
  logic        pix_en;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active, hsync_in, vsync_in, screen_end, grid_en;
  logic [19:0] clear_rows;
  logic [11:0] mem_addr;
  logic        mem_ren;
  logic [2:0]  mem_data;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  logic [23:0] b_clear_rows;
  logic [11:0] b_mem_addr;
  logic        b_mem_ren;
  logic [2:0]  b_mem_data;
  logic [11:0] b_rgb;
  logic        b_hsync_out, b_vsync_out;

  board_renderer #(.FLASH_FRAMES(FF)) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en), .x(x), .y(y),
    .active(active), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .screen_end(screen_end), .grid_en(grid_en), .clear_rows(clear_rows),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_data(mem_data),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  board_renderer #(.COLS(12), .ROWS(24), .CELL(16), .ORIGIN_X(100),
                   .ORIGIN_Y(48), .BASE_ADDR(256)) dut_b (
    .clock(clock), .reset(reset), .pix_en(pix_en), .x(x), .y(y),
    .active(active), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .screen_end(screen_end), .grid_en(grid_en), .clear_rows(b_clear_rows),
    .mem_addr(b_mem_addr), .mem_ren(b_mem_ren), .mem_data(b_mem_data),
    .rgb(b_rgb), .hsync_out(b_hsync_out), .vsync_out(b_vsync_out)
  );

  // Board RAM: data follows the address one clock later
  logic [2:0] ram [0:4095];
  always @(posedge clock) mem_data <= ram[mem_addr];

  // Scoreboard and reference state
  logic [13:0] exp_q[$];
  int          errors;
  int          checks;
  logic [19:0] m_mask;
  int          m_cnt;
  logic        m_phase;
  logic [11:0] m_last_addr;
  bit          seen [0:199];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pal(input logic [2:0] c);
    case (c)
      3'd0: return 12'h000;
      3'd1: return 12'h0FF;
      3'd2: return 12'hFF0;
      3'd3: return 12'h4F0;
      3'd4: return 12'hF00;
      3'd5: return 12'hA0F;
      3'd6: return 12'hE80;
      default: return 12'h02F;
    endcase
  endfunction

  function automatic logic model_inb(input int px, input int py, input logic act);
    return act && px >= OX && px < OX + COLS * CELL && py >= OY && py < OY + ROWS * CELL;
  endfunction

  function automatic logic [11:0] model_rgb(input int px, input int py, input logic act);
    int c, r, xs, ys;
    if (!model_inb(px, py, act)) return 12'h000;
    c  = (px - OX) / CELL;
    xs = (px - OX) % CELL;
    r  = (py - OY) / CELL;
    ys = (py - OY) % CELL;
    if (grid_en && (xs == 0 || xs == CELL - 1 || ys == 0 || ys == CELL - 1)) return 12'hFFF;
    if (m_mask[r] && m_phase) return 12'hFFF;
    return pal(ram[r * COLS + c]);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b1, 12'h000});
    exp_q.push_back({1'b1, 1'b1, 12'h000});
    m_last_addr = 12'd0;
    m_mask      = '0;
    m_cnt       = 0;
    m_phase     = 1'b0;
  endtask

  // Driver: one pixel = one pix_en clock plus one idle clock; starts and ends at negedge
  task automatic tick(input int px, input int py, input logic act,
                      input logic hs, input logic vs, input logic se);
    logic [13:0] e;
    logic        inb;
    x = 10'(px); y = 9'(py); active = act;
    hsync_in = hs; vsync_in = vs; screen_end = se; pix_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    pix_en = 1'b0;
    screen_end = 1'b0;
    if (se) begin
      m_mask = clear_rows;
      if (clear_rows == '0) begin
        m_cnt = 0; m_phase = 1'b0;
      end else if (m_cnt == FF - 1) begin
        m_cnt = 0; m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
    inb = model_inb(px, py, act);
    check("mem_ren", {31'd0, mem_ren}, {31'd0, inb});
    if (inb) m_last_addr = 12'(((py - OY) / CELL) * COLS + (px - OX) / CELL);
    check("mem_addr", {20'd0, mem_addr}, {20'd0, m_last_addr});
    if (mem_ren && mem_addr < 200) seen[mem_addr] = 1'b1;
    exp_q.push_back({hs, vs, model_rgb(px, py, act)});
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      check("pipe", {18'd0, hsync_out, vsync_out, rgb}, {18'd0, e});
    end
    @(negedge clock);
  endtask

  task automatic flush();
    repeat (3) tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic scan(input int py, input int x0, input int x1);
    for (int px = x0; px <= x1; px++) tick(px, py, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  function automatic bit full_line(input int py);
    if (py == 39 || py == 40 || py == 439 || py == 440) return 1'b1;
    return ((py - OY) % CELL == 10);
  endfunction

  logic [11:0] flash_tbl [0:7];
  logic [23:0] hp, vp;
  int          nseen;

  initial begin
    errors = 0; checks = 0;
    reset = 1'b0; pix_en = 1'b0; x = '0; y = '0; active = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; screen_end = 1'b0; grid_en = 1'b0;
    clear_rows = '0; b_clear_rows = '0; b_mem_data = 3'd0;
    for (int i = 0; i < 4096; i++) ram[i] = 3'd0;
    for (int i = 0; i < 200; i++) seen[i] = 1'b0;

    // Power-on reset values
    repeat (3) @(negedge clock);
    check("rst_rgb",  {20'd0, rgb}, 32'h000);
    check("rst_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_ren",  {31'd0, mem_ren}, 32'd0);
    check("rst_hs",   {31'd0, hsync_out}, 32'd1);
    check("rst_vs",   {31'd0, vsync_out}, 32'd1);
    reset = 1'b1;
    model_reset();

    // Cell (3,2)=5 with grid on, then the same pixel with grid off
    ram[23] = 3'd5;
    grid_en = 1'b1;
    tick(OX, OY, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int py = 41; py <= 89; py++) tick(OX, py, 1'b1, 1'b1, 1'b1, 1'b0);
    scan(90, 219, 282);
    check("grid_280", {20'd0, rgb}, 32'hFFF);
    scan(90, 283, 290);
    check("addr_23", {20'd0, mem_addr}, 32'd23);
    scan(90, 291, 292);
    check("cell_290", {20'd0, rgb}, 32'hA0F);
    flush();
    grid_en = 1'b0;
    scan(91, 219, 282);
    check("nogrid_280", {20'd0, rgb}, 32'hA0F);
    for (int px = 283; px <= 286; px++) tick(px, 91, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_hs", {31'd0, hsync_out}, 32'd0);

    // Asynchronous reset mid-frame
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_rgb",  {20'd0, rgb}, 32'h000);
    check("arst_addr", {20'd0, mem_addr}, 32'd0);
    check("arst_ren",  {31'd0, mem_ren}, 32'd0);
    check("arst_hs",   {31'd0, hsync_out}, 32'd1);
    check("arst_vs",   {31'd0, vsync_out}, 32'd1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Full frame with cell i holding i%8, boundary lines and columns included
    for (int i = 0; i < 200; i++) ram[i] = 3'(i % 8);
    for (int py = 39; py <= 440; py++) begin
      if (full_line(py)) scan(py, 219, 420);
      else tick(OX, py, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    nseen = 0;
    for (int i = 0; i < 200; i++) if (seen[i]) nseen++;
    check("addr_cover", nseen, 200);

    // Row-19 flash across frames; mask cleared mid-frame in frame 6
    for (int i = 0; i < 200; i++) ram[i] = 3'd4;
    flash_tbl[0] = 12'hF00; flash_tbl[1] = 12'hF00; flash_tbl[2] = 12'hFFF;
    flash_tbl[3] = 12'hFFF; flash_tbl[4] = 12'hF00; flash_tbl[5] = 12'hF00;
    flash_tbl[6] = 12'hFFF; flash_tbl[7] = 12'hF00;
    clear_rows = 20'h80000;
    for (int f = 0; f < 8; f++) begin
      tick(OX, OY, 1'b1, 1'b1, 1'b1, f > 0);
      for (int py = 41; py <= 440; py++) begin
        if (py == 430) begin
          for (int px = 219; px <= 420; px++) begin
            tick(px, py, 1'b1, 1'b1, 1'b1, 1'b0);
            if (px == 302) check($sformatf("flash_f%0d", f), {20'd0, rgb}, {20'd0, flash_tbl[f]});
          end
          if (f == 6) clear_rows = '0;
        end else if (py == 50) begin
          scan(py, 219, 260);
          check($sformatf("row0_f%0d", f), {20'd0, rgb}, 32'hF00);
        end else begin
          tick(OX, py, 1'b1, 1'b1, 1'b1, 1'b0);
        end
      end
    end

    // Sync delay with arbitrary patterns
    hp = 24'b1011_0010_0111_0001_1100_1010;
    vp = 24'b0110_1101_0001_1110_0100_0011;
    for (int i = 0; i < 24; i++) begin
      tick(0, 0, 1'b0, hp[i], vp[i], 1'b0);
      if (i >= 2) begin
        check("hsync_d3", {31'd0, hsync_out}, {31'd0, hp[i-2]});
        check("vsync_d3", {31'd0, vsync_out}, {31'd0, vp[i-2]});
      end
    end

    // Blanking inside the board
    tick(OX, OY, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int px = 221; px <= 232; px++) tick(px, OY + 5, px % 2 == 1, 1'b1, 1'b1, 1'b0);
    flush();

    // Alternate geometry: x=120,y=70 maps to 256+12+1
    tick(100, 48, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int py = 49; py <= 69; py++) tick(100, py, 1'b1, 1'b1, 1'b1, 1'b0);
    scan(70, 99, 120);
    check("b_addr_269", {20'd0, b_mem_addr}, 32'd269);
    check("b_ren", {31'd0, b_mem_ren}, 32'd1);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
- Parametrised, pipelined playfield renderer for the VGA output path.
- Takes pixel coordinates and sync signals from the VGA timing generator and fetches one cell colour code per pixel from board RAM.
- Outputs 12-bit RGB with hSync/vSync delayed to match the pipeline.
- Generalises the fixed 10x20 board with new features: configurable geometry, counter-based cell addressing (no dividers or multipliers), runtime grid enable, and a frame-timed row-flash for the line-clear animation.

Parameters:
- COLS, 10, board width in cells
- ROWS, 20, board height in cells
- CELL, 20, cell edge in pixels (>=3)
- ORIGIN_X, 220, left pixel column of board
- ORIGIN_Y, 40, top pixel row of board
- ADDR_WIDTH, 12, board RAM address width
- BASE_ADDR, 0, RAM address of cell (0,0)
- FLASH_FRAMES, 8, frames per flash half-period (>=1)

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel strobe; never high on two consecutive clocks
- x  in  10  pixel column from timing generator
- y  in  9  pixel row from timing generator
- active  in  1  visible-region flag
- hsync_in  in  1  raw hSync
- vsync_in  in  1  raw vSync
- screen_end  in  1  one-pix_en pulse between frames
- grid_en  in  1  draw white cell outlines
- clear_rows  in  ROWS  rows to flash (bit r = board row r)
- mem_addr  out  ADDR_WIDTH  board RAM read address
- mem_ren  out  1  read request (pixel inside board)
- mem_data  in  3  cell code; valid one clock after mem_addr changes
- rgb  out  12  {R,G,B} 4 bits each
- hsync_out  out  1  hsync_in delayed 3 pix_en ticks
- vsync_out  out  1  vsync_in delayed 3 pix_en ticks

Behaviour:
- All state advances only on clocks where pix_en=1. On other clocks the state holds.
- Reset (reset=0, asynchronous) sets the following values:
  - rgb=0, mem_addr=BASE_ADDR, mem_ren=0, hsync_out=1, vsync_out=1.
  - All counters, pipeline valid/active bits, flash_mask, frame counter and flash phase are 0.
  - Deassertion is effective on the next pix_en. No output may glitch mid-operation; every output is registered.
- Horizontal tracking registers col/xsub:
  - At x==ORIGIN_X: col=0, xsub=0.
  - Else, for ORIGIN_X<x<ORIGIN_X+COLS*CELL: xsub increments. At xsub==CELL-1 it wraps to 0 and col increments.
- Vertical tracking registers row/ysub/row_base update once per line, at x==ORIGIN_X:
  - If y==ORIGIN_Y: row=0, ysub=0, row_base=0.
  - Else if y is in range: ysub increments. At wrap, row increments and row_base += COLS.
- in_board = x in [ORIGIN_X, ORIGIN_X+COLS*CELL) and y in [ORIGIN_Y, ORIGIN_Y+ROWS*CELL) and active.
- Stage 1 (pixel n):
  - mem_addr <= BASE_ADDR + row_base + col; mem_ren <= in_board.
  - Register the following: in_board, row, is_grid, active, hsync_in, vsync_in.
  - is_grid = xsub==0 or xsub==CELL-1 or ysub==0 or ysub==CELL-1.
- Stage 2: capture mem_data and forward the stage-1 flags.
- Stage 3 (output registers): rgb priority is:
  1. !active -> 000
  2. !in_board -> 000
  3. grid_en & is_grid -> FFF
  4. flash_mask[row] & phase -> FFF
  5. palette[mem_data]
- Palette: 0 000, 1 0FF, 2 FF0, 3 4F0, 4 F00, 5 A0F, 6 E80, 7 02F.
- Latency: exactly 3 pix_en ticks for rgb, hsync_out and vsync_out relative to x/y/sync inputs.
- Flash:
  - On pix_en with screen_end=1: flash_mask <= clear_rows.
  - If the new mask is 0, the frame counter and phase are forced to 0.
  - Otherwise the frame counter increments. At FLASH_FRAMES-1 it wraps to 0 and phase toggles.
  - A mask change mid-frame has no effect until the next screen_end.
- Boundaries:
  - Last pixel column/row of the board renders normally.
  - The pixel at x=ORIGIN_X+COLS*CELL is black.
  - mem_addr holds its last value while mem_ren=0.
  - screen_end coincident with x==ORIGIN_X: both updates apply.

Test Plan:
- Reset mid-frame (reset=0 for 3 clocks): rgb=000, mem_addr=0, hsync_out=vsync_out=1 immediately (asynchronous). After release, first valid rgb appears 3 pix_en later.
- RAM model with cell (3,2)=5, grid_en=1, pixel x=290,y=90: mem_addr=23 one pix_en later and rgb=A0F 3 pix_en later. Pixel x=280,y=90 (xsub=0) gives FFF. With grid_en=0, the same pixel gives A0F.
- Full frame with RAM filled cell i = i%8: every inside pixel matches palette[(10*row+col)%8]. The scan is boundary x=219/420 and y=39/440 -> 000. Addresses 0..199 are each issued; mem_ren=0 outside the board.
- clear_rows=bit19, FLASH_FRAMES=2, RAM all 4, grid_en=0: row 19 reads F00,F00,FFF,FFF,F00 across consecutive frames. Other rows stay F00. Setting clear_rows=0 returns row 19 to F00 from the next frame.
- Toggle hsync_in/vsync_in patterns: hsync_out/vsync_out reproduce them delayed exactly 3 pix_en ticks, with pix_en every 2nd clock.
- Parameter set COLS=12, ROWS=24, CELL=16, ORIGIN_X=100, ORIGIN_Y=48, BASE_ADDR=256: pixel x=120,y=70 maps to mem_addr=256+12+1=269.
